// File: rtl/drone_dock_responder.sv
// Building-side responder for the drone delivery controller: takes delivery
// orders, models the shaft position, raises recipient calls and retires drops.
module drone_dock_responder #(
    parameter int TRAVEL_CYC = 4,
    parameter int CALL_DLY   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       order_valid,
    input  logic [1:0] order_floor,
    output logic       order_ready,
    input  logic [1:0] Motor,
    input  logic [1:0] Drop,
    output logic [1:0] Floor,
    output logic [1:0] FS,
    output logic [1:0] Call,
    output logic [7:0] done_cnt,
    output logic       fault
);

    localparam int POS_MAX = 2 * TRAVEL_CYC;
    localparam int POS_W   = $clog2(POS_MAX + 1);
    localparam int DW_W    = (CALL_DLY > 1) ? $clog2(CALL_DLY) : 1;

    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_FL1  = POS_W'(TRAVEL_CYC);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(CALL_DLY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        pend_reg, pend_next;
    logic [1:0]        call_reg, call_next;
    logic [POS_W-1:0]  pos_reg, pos_next;
    logic [DW_W-1:0]   dwell_reg, dwell_next;
    logic [7:0]        done_reg, done_next;
    logic              fault_reg, fault_next;

    logic              motor_fault;
    logic              accept;
    logic              at_pending;
    logic              dwell_hit;
    logic [1:0]        fs_dec;
    logic [1:0]        drop_ok;
    logic [1:0]        drop_bad;

    // All outputs are decoded from registers only.
    assign fs_dec      = {pos_reg == POS_TOP, pos_reg == POS_FL1};
    assign FS          = fs_dec;
    assign order_ready = (state_reg == IDLE);
    assign Floor       = (state_reg == ISSUE) ? pend_reg : 2'b00;
    assign Call        = call_reg;
    assign done_cnt    = done_reg;
    assign fault       = fault_reg;

    assign accept = order_valid && (order_floor != 2'b00);

    always_comb begin
        pos_next    = pos_reg;
        motor_fault = 1'b0;
        case (Motor)
            2'b01: begin
                if (pos_reg < POS_TOP) pos_next = pos_reg + 1'b1;
                else                   motor_fault = 1'b1;
            end
            2'b10: begin
                if (pos_reg != '0) pos_next = pos_reg - 1'b1;
                else               motor_fault = 1'b1;
            end
            2'b11:   motor_fault = 1'b1;
            default: pos_next = pos_reg;
        endcase
    end

    // FS is one-hot, so a single dwell counter serves both floors.
    assign at_pending = (|(fs_dec & pend_reg & ~call_reg)) && (Motor == 2'b00);
    assign dwell_hit  = at_pending && (dwell_reg == DW_LAST);

    always_comb begin
        dwell_next = '0;
        if (at_pending && !dwell_hit) dwell_next = dwell_reg + 1'b1;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_floor
            assign drop_ok[gi]  = Drop[gi] & call_reg[gi];
            assign drop_bad[gi] = Drop[gi] & ~call_reg[gi];
            // Drop retires the call; leaving the floor withdraws it but keeps pend.
            assign call_next[gi] = drop_ok[gi]  ? 1'b0 :
                                   !fs_dec[gi]  ? 1'b0 :
                                   (dwell_hit && pend_reg[gi]) ? 1'b1 :
                                   call_reg[gi];
        end
    endgenerate

    assign done_next  = done_reg + {7'd0, drop_ok[0]} + {7'd0, drop_ok[1]};
    assign fault_next = fault_reg | motor_fault | (|drop_bad);

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg & ~drop_ok;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    pend_next  = order_floor;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (pend_reg == 2'b00 && pos_reg == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            pend_reg  <= 2'b00;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            call_reg  <= 2'b00;
            pos_reg   <= '0;
            dwell_reg <= '0;
            done_reg  <= 8'd0;
            fault_reg <= 1'b0;
        end else begin
            call_reg  <= call_next;
            pos_reg   <= pos_next;
            dwell_reg <= dwell_next;
            done_reg  <= done_next;
            fault_reg <= fault_next;
        end
    end

endmodule

// File: tb/tb_drone_dock_responder.sv
// Directed bench for drone_dock_responder (TRAVEL_CYC=4, CALL_DLY=2); one line
// per check, immediate assertions at every comparison point.
module tb_drone_dock_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       order_valid;
    logic [1:0] order_floor;
    logic       order_ready;
    logic [1:0] Motor;
    logic [1:0] Drop;
    logic [1:0] Floor;
    logic [1:0] FS;
    logic [1:0] Call;
    logic [7:0] done_cnt;
    logic       fault;

    int n_asserts  = 0;
    int n_failures = 0;

    drone_dock_responder #(.TRAVEL_CYC(4), .CALL_DLY(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .order_valid (order_valid),
        .order_floor (order_floor),
        .order_ready (order_ready),
        .Motor       (Motor),
        .Drop        (Drop),
        .Floor       (Floor),
        .FS          (FS),
        .Call        (Call),
        .done_cnt    (done_cnt),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic motor(input logic [1:0] m, input int n);
        Motor = m;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) begin
            $display("check %0d %s: got %0d", n_asserts, tag, obs);
        end else begin
            n_failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic order(input logic [1:0] f);
        order_valid = 1'b1;
        order_floor = f;
        tick();
        order_valid = 1'b0;
        order_floor = 2'b00;
    endtask

    task automatic pulse_drop(input logic [1:0] d);
        Drop = d;
        tick();
        Drop = 2'b00;
    endtask

    task automatic pulse_rst();
        Motor = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; order_valid = 1'b0; order_floor = 2'b00;
        Motor = 2'b00; Drop = 2'b00;
        tick(); tick();
        check("rst_floor", {6'd0, Floor}, 8'd0);
        check("rst_fs", {6'd0, FS}, 8'd0);
        check("rst_call", {6'd0, Call}, 8'd0);
        check("rst_done", done_cnt, 8'd0);
        check("rst_fault", {7'd0, fault}, 8'd0);
        check("rst_ready", {7'd0, order_ready}, 8'd1);
        rst = 1'b0;

        // Invalid order 00 is ignored without fault
        order(2'b00);
        check("inv_ready", {7'd0, order_ready}, 8'd1);
        check("inv_floor", {6'd0, Floor}, 8'd0);
        check("inv_fault", {7'd0, fault}, 8'd0);

        // Single floor1 delivery
        order(2'b01);
        check("s_floor_pulse", {6'd0, Floor}, 8'd1);
        check("s_ready_busy", {7'd0, order_ready}, 8'd0);
        tick();
        check("s_floor_end", {6'd0, Floor}, 8'd0);
        motor(2'b01, 3);
        check("s_fs_between", {6'd0, FS}, 8'd0);
        motor(2'b01, 1);
        check("s_fs_f1", {6'd0, FS}, 8'd1);
        motor(2'b00, 1);
        check("s_call_early", {6'd0, Call}, 8'd0);
        motor(2'b00, 1);
        check("s_call", {6'd0, Call}, 8'd1);
        pulse_drop(2'b01);
        check("s_call_clr", {6'd0, Call}, 8'd0);
        check("s_done", done_cnt, 8'd1);
        motor(2'b10, 4);
        check("s_fs_base", {6'd0, FS}, 8'd0);
        check("s_ready_lag", {7'd0, order_ready}, 8'd0);
        motor(2'b00, 1);
        check("s_ready", {7'd0, order_ready}, 8'd1);
        check("s_fault", {7'd0, fault}, 8'd0);

        // Dual order
        order(2'b11);
        check("d_floor_pulse", {6'd0, Floor}, 8'd3);
        tick();
        motor(2'b01, 4);
        motor(2'b00, 2);
        check("d_call1", {6'd0, Call}, 8'd1);
        pulse_drop(2'b01);
        check("d_done1", done_cnt, 8'd2);
        motor(2'b01, 4);
        check("d_fs_f2", {6'd0, FS}, 8'd2);
        motor(2'b00, 2);
        check("d_call2", {6'd0, Call}, 8'd2);
        pulse_drop(2'b10);
        check("d_done2", done_cnt, 8'd3);
        motor(2'b10, 8);
        motor(2'b00, 1);
        check("d_ready", {7'd0, order_ready}, 8'd1);
        check("d_fault", {7'd0, fault}, 8'd0);

        // Early departure keeps the floor pending
        order(2'b01);
        tick();
        motor(2'b01, 4);
        motor(2'b00, 2);
        check("e_call", {6'd0, Call}, 8'd1);
        motor(2'b01, 1);
        motor(2'b00, 1);
        check("e_call_left", {6'd0, Call}, 8'd0);
        motor(2'b10, 5);
        motor(2'b00, 2);
        check("e_ready_pend", {7'd0, order_ready}, 8'd0);
        check("e_fs_base", {6'd0, FS}, 8'd0);
        motor(2'b01, 4);
        motor(2'b00, 2);
        check("e_call_retry", {6'd0, Call}, 8'd1);
        pulse_drop(2'b01);
        check("e_done", done_cnt, 8'd4);
        motor(2'b10, 4);
        motor(2'b00, 1);
        check("e_ready", {7'd0, order_ready}, 8'd1);
        check("e_fault", {7'd0, fault}, 8'd0);

        // Protocol errors
        pulse_drop(2'b10);
        check("p_drop_fault", {7'd0, fault}, 8'd1);
        check("p_drop_done", done_cnt, 8'd4);
        pulse_rst();
        check("p_rst_fault", {7'd0, fault}, 8'd0);
        check("p_rst_done", done_cnt, 8'd0);
        motor(2'b10, 1);
        check("p_under_fault", {7'd0, fault}, 8'd1);
        check("p_under_fs", {6'd0, FS}, 8'd0);
        pulse_rst();
        motor(2'b01, 4);
        check("p_idle_move_fs", {6'd0, FS}, 8'd1);
        check("p_idle_move_fault", {7'd0, fault}, 8'd0);
        motor(2'b11, 1);
        check("p_illegal_fault", {7'd0, fault}, 8'd1);
        check("p_illegal_hold", {6'd0, FS}, 8'd1);
        motor(2'b00, 1);
        check("p_hold_fs", {6'd0, FS}, 8'd1);
        pulse_rst();

        // Reset mid-delivery
        order(2'b11);
        tick();
        motor(2'b01, 6);
        check("r_fs_mid", {6'd0, FS}, 8'd0);
        check("r_ready_busy", {7'd0, order_ready}, 8'd0);
        pulse_rst();
        check("r_fs", {6'd0, FS}, 8'd0);
        check("r_call", {6'd0, Call}, 8'd0);
        check("r_ready", {7'd0, order_ready}, 8'd1);
        check("r_floor", {6'd0, Floor}, 8'd0);
        order(2'b10);
        check("r_new_floor", {6'd0, Floor}, 8'd2);
        check("r_new_busy", {7'd0, order_ready}, 8'd0);
        tick();
        check("r_new_floor_end", {6'd0, Floor}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/drone_dock_responder.md
Name: drone_dock_responder

Overview:
- Building-side counterpart of the drone delivery controller; it produces the controller's inputs and consumes its outputs.
- Accepts delivery orders and issues the one-cycle Floor request.
- Models the shaft position from Motor commands and drives the one-hot floor sensor FS.
- Raises the recipient Call after the drone dwells at a pending floor, and retires the delivery on Drop.

Parameters:
TRAVEL_CYC, 4, motor-active cycles per floor of travel (floor1 at pos=TRAVEL_CYC, floor2 at pos=2*TRAVEL_CYC, base at pos=0)
CALL_DLY, 2, stopped cycles at a pending floor before Call asserts (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
order_valid  input  1  new delivery order offered
order_floor  input  2  order floors: bit0=floor1, bit1=floor2; 00 is never accepted
order_ready  output  1  order accepted when order_valid && order_ready && order_floor!=0
Motor  input  2  from drone: 00 stop, 01 up, 10 down, 11 illegal
Drop  input  2  from drone: bit n = package dropped at floor n+1
Floor  output  2  to drone: delivery request, one-cycle pulse
FS  output  2  to drone: floor sensor, one-hot or 00
Call  output  2  to drone: recipient present at floor n+1
done_cnt  output  8  completed drops, wraps 255->0
fault  output  1  sticky protocol/limit error

Behaviour:
- Single clock; reset is synchronous, active-high.
- Reset, on the edge with rst=1:
  - state=IDLE, pend=00, pos=0, dwell=0.
  - Floor=00, Call=00, done_cnt=0, fault=0.
  - FS=00, since it is decoded from pos=0.
  - order_ready=1, since it is decoded from state==IDLE.
  - Reset mid-delivery discards all pending work identically.
- Dispatcher FSM:
  - IDLE: order_ready=1. On acceptance, pend<=order_floor and go to ISSUE. Invalid orders (00) are ignored, no fault.
  - ISSUE: Floor=pend for exactly this one cycle; go to WAIT. order_ready=0.
  - WAIT: order_ready=0. Go to IDLE when pend==00 && pos==0.
  - Floor=00 in every state except ISSUE.
- Position, registered and updated every cycle:
  - Motor=01 and pos<2*TRAVEL_CYC: pos+1.
  - Motor=10 and pos>0: pos-1.
  - Motor=01 at the top limit, Motor=10 at 0, or Motor=11: pos held, fault<=1.
  - Motor=00: pos held.
  - Motor is honoured in every state, including IDLE.
  - Width is clog2(2*TRAVEL_CYC+1).
- FS is decoded from the pos register (one cycle after the Motor edge that reaches the floor):
  - FS=01 iff pos==TRAVEL_CYC.
  - FS=10 iff pos==2*TRAVEL_CYC.
  - Otherwise FS=00.
- Dwell/Call:
  - dwell increments while FS[n]=1 && Motor==00 && pend[n]=1 && Call[n]=0.
  - When dwell==CALL_DLY-1 on such a cycle, Call[n]<=1 on that edge and dwell<=0.
  - Any cycle with Motor!=00 or FS changing resets dwell.
  - Call[n] deasserts on the next edge if FS[n] becomes 0 (drone left early). pend[n] is kept, so a retry is possible.
- Drop handling, each bit independent:
  - Drop[n]=1 && Call[n]=1: pend[n]<=0, Call[n]<=0, done_cnt<=done_cnt+1.
  - Drop[n]=1 && Call[n]=0: ignored, fault<=1.
  - Both Drop bits high together: each bit is evaluated separately. Only one Call can be high at a time, so at least one bit faults.
- fault clears only on rst.
- No combinational path from any input to any output. Outputs depend only on registers (order_ready, FS are decoded from state/pos).

Test Plan:
All scenarios use TRAVEL_CYC=4, CALL_DLY=2.
- Reset: hold rst 2 cycles -> Floor=00, FS=00, Call=00, done_cnt=0, fault=0, order_ready=1.
- Single floor1 order:
  - order_floor=01 accepted -> Floor=01 for exactly one cycle, order_ready=0.
  - Motor=01 for 4 cycles -> FS=01.
  - Motor=00 for 2 cycles -> Call=01.
  - Drop=01 -> Call=00 next cycle, done_cnt=1.
  - Motor=10 for 4 cycles -> FS=00, order_ready=1.
- Dual order:
  - order_floor=11 -> Floor=11 pulse.
  - Serve floor1 (Call=01, Drop=01), climb 4 more cycles -> FS=10; dwell -> Call=10, Drop=10.
  - Return to 0 -> done_cnt=+2, order_ready=1, fault=0.
- Early departure:
  - At floor1 with Call=01, Motor=01 -> Call=00 next cycle, pend kept, order_ready stays 0 after return to 0.
  - Re-serve floor1 -> completes normally.
- Protocol errors:
  - Drop=10 while Call=00 -> fault=1, done_cnt unchanged.
  - Separately, Motor=10 at pos=0 -> fault=1, FS=00.
  - Motor=11 -> fault=1, pos held.
- Reset mid-delivery:
  - rst at pos=6 during WAIT -> next cycle FS=00, Call=00, pend cleared, order_ready=1.
  - A fresh order is then accepted.
